// File: rtl/umi_req_fifo.sv
// Request FIFO on the UMI device request channel, feeding the simple endpoint's udev_req_* inputs.
// Packets pass through unmodified; occupancy is exported for status.
module umi_req_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    umi_in_valid,
    input  logic [CW-1:0]           umi_in_cmd,
    input  logic [AW-1:0]           umi_in_dstaddr,
    input  logic [AW-1:0]           umi_in_srcaddr,
    input  logic [DW-1:0]           umi_in_data,
    output logic                    umi_in_ready,
    output logic                    umi_out_valid,
    output logic [CW-1:0]           umi_out_cmd,
    output logic [AW-1:0]           umi_out_dstaddr,
    output logic [AW-1:0]           umi_out_srcaddr,
    output logic [DW-1:0]           umi_out_data,
    input  logic                    umi_out_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fifo_full,
    output logic                    fifo_empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int EW = CW + 2 * AW + DW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          push, pop;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];

    // The wrap bit distinguishes full from empty when the indices coincide.
    assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
    assign fifo_full     = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign fifo_count    = count_q;
    assign umi_in_ready  = !fifo_full;
    assign umi_out_valid = !fifo_empty;

    assign push = umi_in_valid & umi_in_ready;
    assign pop  = umi_out_valid & umi_out_ready;

    assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = mem_q[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + PW'(push) - PW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; entries are only observable once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_idx] <= {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
        end
    end

    a_depth_pow2: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && fifo_empty));
    a_count_ptrs: assert property (@(posedge clk) disable iff (reset)
        count_q == PW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_umi_req_fifo.sv
// Bench for umi_req_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_umi_req_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int EW    = CW + 2 * AW + DW;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } pkt_t;

    logic                   clk = 1'b0;
    logic                   reset, clear;
    logic                   umi_in_valid, umi_in_ready;
    logic [CW-1:0]          umi_in_cmd;
    logic [AW-1:0]          umi_in_dstaddr, umi_in_srcaddr;
    logic [DW-1:0]          umi_in_data;
    logic                   umi_out_valid, umi_out_ready;
    logic [CW-1:0]          umi_out_cmd;
    logic [AW-1:0]          umi_out_dstaddr, umi_out_srcaddr;
    logic [DW-1:0]          umi_out_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full, fifo_empty;

    int checks   = 0;
    int failures = 0;

    pkt_t model_q[$];
    bit   model_on = 1'b0;

    umi_req_fifo #(.DEPTH(DEPTH), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .fifo_count      (fifo_count),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain queue semantics evaluated at each rising edge.
    always @(posedge clk) begin
        bit m_push, m_pop;
        if (reset) begin
            model_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            m_pop  = (model_q.size() > 0) && umi_out_ready;
            m_push = umi_in_valid && (model_q.size() < DEPTH);
            if (clear) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) model_q.push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
            end
        end
    end

    // Compare process on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("m_valid", EW'(umi_out_valid), EW'(model_q.size() != 0));
            check("m_ready", EW'(umi_in_ready), EW'(model_q.size() < DEPTH));
            check("m_count", EW'(fifo_count), EW'(model_q.size()));
            check("m_full",  EW'(fifo_full),  EW'(model_q.size() == DEPTH));
            check("m_empty", EW'(fifo_empty), EW'(model_q.size() == 0));
            if (model_q.size() != 0) begin
                check("m_payload",
                      {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data},
                      model_q[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        umi_in_valid   = v;
        umi_in_cmd     = 32'h5;
        umi_in_dstaddr = 64'h1000;
        umi_in_srcaddr = 64'h2000;
        umi_in_data    = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        umi_out_ready = 1'b0;
        drive(1'b0, '0);
        step();
        step();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_valid", EW'(umi_out_valid), EW'(0));
            check("idle_ready", EW'(umi_in_ready), EW'(1));
            check("idle_empty", EW'(fifo_empty), EW'(1));
            check("idle_count", EW'(fifo_count), EW'(0));
        end

        // Single packet, one-cycle latency.
        umi_out_ready = 1'b1;
        drive(1'b1, {32{8'hA5}});
        step();
        drive(1'b0, '0);
        check("single_valid", EW'(umi_out_valid), EW'(1));
        check("single_count", EW'(fifo_count), EW'(1));
        check("single_cmd", EW'(umi_out_cmd), EW'(32'h5));
        check("single_dst", EW'(umi_out_dstaddr), EW'(64'h1000));
        check("single_src", EW'(umi_out_srcaddr), EW'(64'h2000));
        check("single_data", EW'(umi_out_data), EW'({32{8'hA5}}));
        step();
        check("single_count_after", EW'(fifo_count), EW'(0));
        check("single_valid_after", EW'(umi_out_valid), EW'(0));

        // Fill to full with the consumer stalled.
        umi_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i));
            step();
        end
        check("fill_full", EW'(fifo_full), EW'(1));
        check("fill_ready", EW'(umi_in_ready), EW'(0));
        check("fill_count", EW'(fifo_count), EW'(4));
        drive(1'b1, DW'(5));
        step();
        check("fill_5th_rejected", EW'(fifo_count), EW'(4));
        drive(1'b0, '0);
        umi_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", EW'(umi_out_data), EW'(i));
            step();
        end
        check("drain_empty", EW'(fifo_empty), EW'(1));

        // Steady state at count 2 with pointers wrapping.
        umi_out_ready = 1'b0;
        drive(1'b1, DW'(100));
        step();
        drive(1'b1, DW'(101));
        step();
        umi_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(102 + i));
            check("stream_head", EW'(umi_out_data), EW'(100 + i));
            step();
            check("stream_count", EW'(fifo_count), EW'(2));
        end
        drive(1'b0, '0);
        check("stream_tail0", EW'(umi_out_data), EW'(120));
        step();
        check("stream_tail1", EW'(umi_out_data), EW'(121));
        step();
        check("stream_empty", EW'(fifo_empty), EW'(1));

        // Clear drops stored packets and a concurrent push.
        umi_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(200 + i));
            step();
        end
        check("preclear_count", EW'(fifo_count), EW'(3));
        clear = 1'b1;
        drive(1'b1, DW'(999));
        step();
        clear = 1'b0;
        drive(1'b0, '0);
        check("clear_valid", EW'(umi_out_valid), EW'(0));
        check("clear_count", EW'(fifo_count), EW'(0));
        umi_out_ready = 1'b1;
        step();
        check("clear_stays_empty", EW'(umi_out_valid), EW'(0));

        // Reset mid-stream discards contents.
        umi_out_ready = 1'b0;
        drive(1'b1, DW'(300));
        step();
        drive(1'b1, DW'(301));
        step();
        drive(1'b0, '0);
        reset = 1'b1;
        umi_out_ready = 1'b1;
        step();
        reset = 1'b0;
        check("reset_valid", EW'(umi_out_valid), EW'(0));
        check("reset_count", EW'(fifo_count), EW'(0));
        drive(1'b1, DW'(400));
        step();
        drive(1'b0, '0);
        check("post_reset_data", EW'(umi_out_data), EW'(400));
        check("post_reset_count", EW'(fifo_count), EW'(1));
        step();
        check("post_reset_empty", EW'(fifo_empty), EW'(1));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
